// File: rtl/sram_port_arbiter.sv
// Purpose: shares one async SRAM among a never-stalled video reader, a queued loader writer and an aux reader.
// Latency: SRAM pins change one edge after the grant; read data returns two edges after the grant.
// Backpressure: video is never stalled; the loader sees o_wr_ready=!full; aux holds its request until o_aux_ack.
module sram_port_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic [DATA_W-1:0] o_vid_data,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_aux_req,
  input  logic [ADDR_W-1:0] i_aux_addr,
  output logic              o_aux_ack,
  output logic              o_aux_rvalid,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_data_oe,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_starve
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WFIFO_DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam logic [1:0] OWN_AUX  = 2'd3;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rel_idx;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic [1:0]        owner, sram_tag;
  logic              rr_aux, push, pop, fifo_ne, aux_hit, aux_elig;

  assign fifo_ne    = (fifo_cnt != '0);
  assign o_wr_ready = (fifo_cnt != FULL_CNT);
  assign push       = i_wr_valid && o_wr_ready;
  assign pop        = (owner == OWN_WR);
  assign aux_elig   = i_aux_req && !aux_hit;
  assign o_aux_ack  = (owner == OWN_AUX) && !i_rst;
  assign o_starve   = (starve_cnt == STV_MAX);

  // Read-after-write guard: aux must wait while its address sits in any live queue slot
  always_comb begin
    aux_hit = 1'b0;
    rel_idx = '0;
    for (int i = 0; i < WFIFO_DEPTH; i++) begin
      rel_idx = PTR_W'(i) - rd_ptr;
      if (({1'b0, rel_idx} < fifo_cnt) && (fifo_addr[i] == i_aux_addr)) aux_hit = 1'b1;
    end
  end

  // Owner of the next SRAM cycle: video first, then round-robin between writer and aux
  always_comb begin
    owner = OWN_IDLE;
    if (i_vid_req)                owner = OWN_VID;
    else if (fifo_ne && aux_elig) owner = rr_aux ? OWN_AUX : OWN_WR;
    else if (fifo_ne)             owner = OWN_WR;
    else if (aux_elig)            owner = OWN_AUX;
  end

  // Queue storage needs no reset; liveness is tracked by the pointers and count
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_wr_addr;
      fifo_data[wr_ptr] <= i_wr_data;
    end
  end

  // Queue pointers and occupancy; a push is refused while full even if a pop happens
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Round-robin pointer hands preference to the other requester after each grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 rr_aux <= 1'b0;
    else if (owner == OWN_WR)  rr_aux <= 1'b1;
    else if (owner == OWN_AUX) rr_aux <= 1'b0;
  end

  // Registered SRAM pins; the address holds across idle cycles
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sram_addr    <= '0;
      o_sram_wdata   <= '0;
      o_sram_data_oe <= 1'b0;
      o_sram_ce_n    <= 1'b1;
      o_sram_oe_n    <= 1'b1;
      o_sram_we_n    <= 1'b1;
      sram_tag       <= OWN_IDLE;
    end else begin
      sram_tag <= owner;
      case (owner)
        OWN_VID, OWN_AUX: begin
          o_sram_addr    <= (owner == OWN_VID) ? i_vid_addr : i_aux_addr;
          o_sram_data_oe <= 1'b0;
          o_sram_ce_n    <= 1'b0;
          o_sram_oe_n    <= 1'b0;
          o_sram_we_n    <= 1'b1;
        end
        OWN_WR: begin
          o_sram_addr    <= fifo_addr[rd_ptr];
          o_sram_wdata   <= fifo_data[rd_ptr];
          o_sram_data_oe <= 1'b1;
          o_sram_ce_n    <= 1'b0;
          o_sram_oe_n    <= 1'b1;
          o_sram_we_n    <= 1'b0;
        end
        default: begin
          o_sram_data_oe <= 1'b0;
          o_sram_ce_n    <= 1'b1;
          o_sram_oe_n    <= 1'b1;
          o_sram_we_n    <= 1'b1;
        end
      endcase
    end
  end

  // Capture read data at the end of the SRAM cycle and steer it by the owner tag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vid_data   <= '0;
      o_aux_rdata  <= '0;
      o_aux_rvalid <= 1'b0;
    end else begin
      o_aux_rvalid <= (sram_tag == OWN_AUX);
      if (sram_tag == OWN_VID) o_vid_data  <= i_sram_rdata;
      if (sram_tag == OWN_AUX) o_aux_rdata <= i_sram_rdata;
    end
  end

  // Saturating wait counter for writer/aux, cleared by any writer or aux grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                        starve_cnt <= '0;
    else if ((owner == OWN_WR) || (owner == OWN_AUX)) starve_cnt <= '0;
    else if ((fifo_ne || i_aux_req) && !o_starve)     starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, hand sequences and random traffic
// against a queue-based reference model with its own copy of SRAM contents.
module tb_sram_port_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int SLIM = 8;
  localparam int M_IDLE = 0, M_VID = 1, M_WR = 2, M_AUX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vid_req = 1'b0, wr_valid = 1'b0, aux_req = 1'b0;
  logic [AW-1:0] vid_addr = '0, wr_addr = '0, aux_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] vid_data, aux_rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;
  logic wr_ready, aux_ack, aux_rvalid, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, starve;

  int total = 0;
  int bad = 0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_data(vid_data),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_aux_req(aux_req), .i_aux_addr(aux_addr), .o_aux_ack(aux_ack),
    .o_aux_rvalid(aux_rvalid), .o_aux_rdata(aux_rdata),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_data_oe(sram_data_oe),
    .o_sram_ce_n(sram_ce_n), .o_sram_oe_n(sram_oe_n), .o_sram_we_n(sram_we_n),
    .i_sram_rdata(sram_rdata), .o_starve(starve)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: combinational read, write at the end of a write cycle
  logic [DW-1:0] sram [0:255];
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) sram[sram_addr[7:0]] <= sram_wdata;
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[7:0]] : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } went_t;
  went_t wq[$];
  logic [DW-1:0] mmem [0:255];
  bit m_rr_write = 1'b1;
  int m_cnt = 0;
  int m_tag = M_IDLE;
  int m_own;
  bit m_ne, m_push;
  logic e_ce = 1'b1, e_oe = 1'b1, e_we = 1'b1, e_doe = 1'b0, e_rv = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_vdat = '0, e_ardat = '0;

  function automatic int m_owner();
    bit hit;
    hit = 1'b0;
    if (rst) return M_IDLE;
    foreach (wq[i]) if (wq[i].a == aux_addr) hit = 1'b1;
    if (vid_req) return M_VID;
    if (wq.size() > 0 && aux_req && !hit) return m_rr_write ? M_WR : M_AUX;
    if (wq.size() > 0) return M_WR;
    if (aux_req && !hit) return M_AUX;
    return M_IDLE;
  endfunction

  // Model advances one SRAM cycle per edge, or clears on reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wq.delete();
      m_rr_write = 1'b1; m_cnt = 0; m_tag = M_IDLE;
      e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_doe = 1'b0; e_rv = 1'b0;
      e_addr = '0; e_wdata = '0; e_vdat = '0; e_ardat = '0;
    end else begin
      m_own  = m_owner();
      m_ne   = wq.size() > 0;
      m_push = wr_valid && (wq.size() < DEPTH);
      if (!e_we) mmem[e_addr[7:0]] = e_wdata;
      e_rv = 1'b0;
      if (m_tag == M_VID) e_vdat = mmem[e_addr[7:0]];
      if (m_tag == M_AUX) begin e_ardat = mmem[e_addr[7:0]]; e_rv = 1'b1; end
      m_tag = m_own;
      case (m_own)
        M_VID: begin e_addr = vid_addr; e_ce = 1'b0; e_oe = 1'b0; e_we = 1'b1; e_doe = 1'b0; end
        M_AUX: begin e_addr = aux_addr; e_ce = 1'b0; e_oe = 1'b0; e_we = 1'b1; e_doe = 1'b0; end
        M_WR: begin
          e_addr = wq[0].a; e_wdata = wq[0].d;
          e_ce = 1'b0; e_oe = 1'b1; e_we = 1'b0; e_doe = 1'b1;
          void'(wq.pop_front());
        end
        default: begin e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_doe = 1'b0; end
      endcase
      if (m_push) wq.push_back({wr_addr, wr_data});
      if (m_own == M_WR) m_rr_write = 1'b0;
      if (m_own == M_AUX) m_rr_write = 1'b1;
      if (m_own == M_WR || m_own == M_AUX) m_cnt = 0;
      else if ((m_ne || aux_req) && m_cnt < SLIM) m_cnt = m_cnt + 1;
    end
  end

  // Every cycle, compare all outputs against the model mid-cycle
  always @(negedge clk) begin
    chk("m_ce_n", 32'(sram_ce_n), 32'(e_ce));
    chk("m_oe_n", 32'(sram_oe_n), 32'(e_oe));
    chk("m_we_n", 32'(sram_we_n), 32'(e_we));
    chk("m_data_oe", 32'(sram_data_oe), 32'(e_doe));
    chk("m_addr", 32'(sram_addr), 32'(e_addr));
    if (!e_we || rst) chk("m_wdata", 32'(sram_wdata), 32'(e_wdata));
    chk("m_vid_data", 32'(vid_data), 32'(e_vdat));
    chk("m_rvalid", 32'(aux_rvalid), 32'(e_rv));
    if (e_rv || rst) chk("m_aux_rdata", 32'(aux_rdata), 32'(e_ardat));
    chk("m_ack", 32'(aux_ack), 32'(m_owner() == M_AUX));
    chk("m_wr_ready", 32'(wr_ready), 32'(wq.size() < DEPTH));
    chk("m_starve", 32'(starve), 32'(m_cnt == SLIM));
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic vid; logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd; logic aux; logic [AW-1:0] aa;
    logic ack; logic rdy; logic ce_n; logic we_n; logic oe_n; logic [AW-1:0] addr;
    logic [DW-1:0] vdat; logic rv;
  } vec_t;
  vec_t tbl [12];

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic a, input logic [AW-1:0] aa);
    vid_req = v; vid_addr = 20'h00010;
    wr_valid = w; wr_addr = wa; wr_data = wd;
    aux_req = a; aux_addr = aa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce_n"}, 32'(sram_ce_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_data_oe"}, 32'(sram_data_oe), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
    chk({tag, "_vid_data"}, 32'(vid_data), 32'd0);
    chk({tag, "_aux_rdata"}, 32'(aux_rdata), 32'd0);
    chk({tag, "_ack"}, 32'(aux_ack), 32'd0);
    chk({tag, "_rvalid"}, 32'(aux_rvalid), 32'd0);
    chk({tag, "_starve"}, 32'(starve), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] v;
    bit acked;
    for (int i = 0; i < 256; i++) begin
      v = 16'(i * 257) ^ 16'h5A5A;
      sram[i] = v;
      mmem[i] = v;
    end
    sram[16] = 16'hBEEF;
    mmem[16] = 16'hBEEF;

    // vid, wv, wa, wd, aux, aa | ack, rdy, ce_n, we_n, oe_n, addr, vid_data, rvalid
    tbl[0]  = '{1'b1, 1'b1, 20'h1, 16'h00A1, 1'b0, 20'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0,  16'h0,    1'b0};
    tbl[1]  = '{1'b1, 1'b1, 20'h2, 16'h00A2, 1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h10, 16'h0,    1'b0};
    tbl[2]  = '{1'b1, 1'b1, 20'h3, 16'h00A3, 1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h10, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 20'h4, 16'h00A4, 1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h10, 16'hBEEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 20'h5, 16'h00A5, 1'b1, 20'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h10, 16'hBEEF, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b1, 20'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h10, 16'hBEEF, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b1, 20'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 20'h1,  16'hBEEF, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h40, 16'hBEEF, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h2,  16'hBEEF, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h3,  16'hBEEF, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b0, 20'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h4,  16'hBEEF, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 20'h0, 16'h0,    1'b0, 20'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 20'h4,  16'hBEEF, 1'b0};

    @(negedge clk);
    chk_reset_vals("por");
    tick();
    rst = 1'b0;

    // Directed table: video then full queue drained W,A,W,W,W
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].vid, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].aux, tbl[i].aa);
      @(negedge clk);
      chk($sformatf("tv%0d_ack", i), 32'(aux_ack), 32'(tbl[i].ack));
      chk($sformatf("tv%0d_rdy", i), 32'(wr_ready), 32'(tbl[i].rdy));
      chk($sformatf("tv%0d_ce_n", i), 32'(sram_ce_n), 32'(tbl[i].ce_n));
      chk($sformatf("tv%0d_we_n", i), 32'(sram_we_n), 32'(tbl[i].we_n));
      chk($sformatf("tv%0d_oe_n", i), 32'(sram_oe_n), 32'(tbl[i].oe_n));
      chk($sformatf("tv%0d_addr", i), 32'(sram_addr), 32'(tbl[i].addr));
      chk($sformatf("tv%0d_vdat", i), 32'(vid_data), 32'(tbl[i].vdat));
      chk($sformatf("tv%0d_rv", i), 32'(aux_rvalid), 32'(tbl[i].rv));
      chk($sformatf("tv%0d_starve", i), 32'(starve), 32'd0);
      tick();
    end

    // Read-after-write: aux to a queued address waits for the write to issue
    drive(1'b1, 1'b1, 20'h5, 16'h1234, 1'b1, 20'h5); @(negedge clk); chk("raw_ack_d0", 32'(aux_ack), 32'd0); tick();
    drive(1'b1, 1'b0, 20'h0, 16'h0, 1'b1, 20'h5);    @(negedge clk); chk("raw_ack_d1", 32'(aux_ack), 32'd0); tick();
    drive(1'b0, 1'b0, 20'h0, 16'h0, 1'b1, 20'h5);    @(negedge clk); chk("raw_ack_d2", 32'(aux_ack), 32'd0); tick();
    @(negedge clk);
    chk("raw_ack_d3", 32'(aux_ack), 32'd1);
    chk("raw_we_n_d3", 32'(sram_we_n), 32'd0);
    chk("raw_addr_d3", 32'(sram_addr), 32'h5);
    tick();
    drive(1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 20'h0); @(negedge clk); tick();
    @(negedge clk);
    chk("raw_rvalid", 32'(aux_rvalid), 32'd1);
    chk("raw_rdata", 32'(aux_rdata), 32'h1234);
    tick();

    // Video held 20 cycles: no writer/aux grant, starvation flag after 8 waiting cycles
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 20'h0, 16'h0, 1'b1, 20'h80);
      if (k < 2) begin wr_valid = 1'b1; wr_addr = 20'h30 + 20'(k); wr_data = 16'h3000 + 16'(k); end
      @(negedge clk);
      chk($sformatf("vh%0d_ack", k), 32'(aux_ack), 32'd0);
      chk($sformatf("vh%0d_we_n", k), 32'(sram_we_n), 32'd1);
      chk($sformatf("vh%0d_rdy", k), 32'(wr_ready), 32'd1);
      chk($sformatf("vh%0d_starve", k), 32'(starve), 32'(k >= 8));
      tick();
    end
    drive(1'b0, 1'b0, 20'h0, 16'h0, 1'b1, 20'h80);
    @(negedge clk); chk("vh20_ack", 32'(aux_ack), 32'd0); chk("vh20_starve", 32'(starve), 32'd1); tick();
    @(negedge clk); chk("vh21_ack", 32'(aux_ack), 32'd1); chk("vh21_starve", 32'(starve), 32'd0); tick();
    drive(1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 20'h0);
    @(negedge clk); tick();
    @(negedge clk); tick();

    // Reset with three queued writes and an aux read in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 20'h50 + 20'(k), 16'h5000 + 16'(k), 1'b0, 20'h0);
      @(negedge clk); tick();
    end
    drive(1'b0, 1'b0, 20'h0, 16'h0, 1'b1, 20'h90);
    @(negedge clk); chk("rst_pre_ack", 32'(aux_ack), 32'd1); tick();
    drive(1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 20'h0);
    rst = 1'b1;
    @(negedge clk); chk_reset_vals("mid"); tick();
    @(negedge clk); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d_rvalid", k), 32'(aux_rvalid), 32'd0);
      chk($sformatf("post%0d_rdy", k), 32'(wr_ready), 32'd1);
      chk($sformatf("post%0d_ce_n", k), 32'(sram_ce_n), 32'd1);
      tick();
    end

    // Random traffic; aux requester holds request and address until acknowledged
    acked = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      vid_req  = ($urandom_range(0, 99) < 35);
      vid_addr = AW'($urandom_range(0, 255));
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, 15));
      wr_data  = DW'($urandom);
      if (aux_req && acked) aux_req = 1'b0;
      if (!aux_req && $urandom_range(0, 99) < 40) begin
        aux_req  = 1'b1;
        aux_addr = AW'($urandom_range(0, 15));
      end
      @(negedge clk);
      acked = (m_owner() == M_AUX);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
